// File: rtl/shift_word_capture.sv
// shift_word_capture: counts shifts from a serial shift register and captures
// each completed word (with its direction tag) into a small FWFT FIFO.
module shift_word_capture #(
    parameter int DATA_WID   = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          shift_en,
    input  logic                          dir,
    input  logic [DATA_WID-1:0]           par_in,
    output logic [DATA_WID-1:0]           word_data,
    output logic                          word_dir,
    output logic                          word_valid,
    input  logic                          word_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          abort,
    output logic                          overflow,
    input  logic                          clr_ovf
);
    localparam int CW = $clog2(DATA_WID);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [CW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                last_dir_q, last_dir_d;
    logic                pend_q, pend_d;
    logic                pend_dir_q, pend_dir_d;
    logic                abort_q, abort_d;
    logic                overflow_q, overflow_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]         count_q, count_d;
    logic [DATA_WID:0]   mem_q [FIFO_DEPTH];
    logic                full, pop, do_push, drop, dir_flip, complete;

    always_comb begin
        dir_flip   = shift_en && (bit_cnt_q != '0) && (dir != last_dir_q);
        complete   = shift_en && !dir_flip && (bit_cnt_q == CW'(DATA_WID - 1));
        bit_cnt_d  = !shift_en ? bit_cnt_q : dir_flip ? CW'(1) : complete ? '0 : bit_cnt_q + CW'(1);
        last_dir_d = shift_en ? dir : last_dir_q;
        pend_d     = complete;
        pend_dir_d = complete ? dir : pend_dir_q;
        abort_d    = dir_flip;
        full       = count_q == (AW+1)'(FIFO_DEPTH);
        word_valid = count_q != '0;
        pop        = word_valid && word_ready;
        // A full FIFO still accepts the push when the head leaves in the same cycle
        do_push    = pend_q && (!full || pop);
        drop       = pend_q && full && !pop;
        overflow_d = drop ? 1'b1 : clr_ovf ? 1'b0 : overflow_q;
        wr_ptr_d   = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d    = (do_push && !pop) ? count_q + (AW+1)'(1) :
                     (pop && !do_push) ? count_q - (AW+1)'(1) : count_q;
        word_data  = word_valid ? mem_q[rd_ptr_q][DATA_WID-1:0] : '0;
        word_dir   = word_valid ? mem_q[rd_ptr_q][DATA_WID] : 1'b0;
        fifo_count = count_q;
        abort      = abort_q;
        overflow   = overflow_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt_q  <= '0;
            last_dir_q <= 1'b0;
            pend_q     <= 1'b0;
            pend_dir_q <= 1'b0;
            abort_q    <= 1'b0;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            bit_cnt_q  <= bit_cnt_d;
            last_dir_q <= last_dir_d;
            pend_q     <= pend_d;
            pend_dir_q <= pend_dir_d;
            abort_q    <= abort_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid
    always_ff @(posedge clk) begin
        if (rst_n && do_push) mem_q[wr_ptr_q] <= {pend_dir_q, par_in};
    end
endmodule

// File: tb/tb_shift_word_capture.sv
// tb_shift_word_capture: directed stimulus with a scoreboard queue of expected
// words and a monitor that checks every word the consumer accepts.
module tb_shift_word_capture;
    logic       clk = 0;
    logic       rst_n = 0;
    logic       shift_en = 0;
    logic       dir = 0;
    logic [7:0] par_in = 0;
    logic [7:0] word_data;
    logic       word_dir;
    logic       word_valid;
    logic       word_ready = 0;
    logic [2:0] fifo_count;
    logic       abort;
    logic       overflow;
    logic       clr_ovf = 0;

    int n_checks = 0;
    int n_fail = 0;
    logic [8:0] exp_q[$];

    shift_word_capture #(.DATA_WID(8), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .shift_en(shift_en), .dir(dir), .par_in(par_in),
        .word_data(word_data), .word_dir(word_dir), .word_valid(word_valid),
        .word_ready(word_ready), .fifo_count(fifo_count), .abort(abort),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && word_valid && word_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL pop_unexpected: got dir=%0d data=%h, none expected", word_dir, word_data);
            end else begin
                logic [8:0] e;
                e = exp_q.pop_front();
                if ({word_dir, word_data} !== e) begin
                    n_fail++;
                    $display("FAIL pop_word: got dir=%0d data=%h, expected dir=%0d data=%h",
                             word_dir, word_data, e[8], e[7:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic shift(input logic d);
        shift_en = 1;
        dir = d;
        tick();
        shift_en = 0;
    endtask

    // n shifts in direction d; the last one completes a word whose parallel value is val
    task automatic word(input logic d, input logic [7:0] val, input bit keep, input bit rdy_at_push);
        for (int i = 0; i < 8; i++) shift(d);
        par_in = val;
        if (keep) exp_q.push_back({d, val});
        word_ready = rdy_at_push;
        tick();
        word_ready = 0;
        par_in = 8'h00;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        word_ready = 1;
        while (fifo_count != 0 && guard < 20) begin
            tick();
            guard++;
        end
        word_ready = 0;
        check("drain_bounded", int'(guard < 20), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: reset held while shifting captures nothing
        rst_n = 0;
        for (int i = 0; i < 8; i++) shift(1);
        par_in = 8'hA5;
        tick();
        tick();
        check("rst_count", fifo_count, 0);
        check("rst_valid", word_valid, 0);
        check("rst_data", word_data, 0);
        check("rst_dir", word_dir, 0);
        check("rst_abort", abort, 0);
        check("rst_ovf", overflow, 0);
        rst_n = 1;
        par_in = 0;
        tick();

        // 2: one left word, valid two cycles after the completing shift
        for (int i = 0; i < 8; i++) shift(1);
        par_in = 8'hFF;
        check("t2_valid_early", word_valid, 0);
        exp_q.push_back({1'b1, 8'hFF});
        tick();
        par_in = 0;
        check("t2_valid", word_valid, 1);
        check("t2_count1", fifo_count, 1);
        check("t2_data", word_data, 8'hFF);
        check("t2_dir", word_dir, 1);
        word_ready = 1;
        tick();
        word_ready = 0;
        check("t2_count0", fifo_count, 0);

        // 3: direction change mid-word aborts, new word starts with that shift
        for (int i = 0; i < 3; i++) shift(1);
        check("t3_no_abort", abort, 0);
        shift(0);
        check("t3_abort", abort, 1);
        shift(0);
        check("t3_abort_pulse", abort, 0);
        for (int i = 0; i < 5; i++) shift(0);
        check("t3_not_yet", fifo_count, 0);
        shift(0);
        par_in = 8'h3C;
        exp_q.push_back({1'b0, 8'h3C});
        tick();
        par_in = 0;
        check("t3_count", fifo_count, 1);
        check("t3_dir", word_dir, 0);
        drain();

        // 4: five words with no consumer -> fifth dropped, overflow sticky
        word(1, 8'h11, 1, 0);
        word(0, 8'h22, 1, 0);
        word(1, 8'h33, 1, 0);
        word(0, 8'h44, 1, 0);
        check("t4_ovf_before", overflow, 0);
        word(1, 8'h55, 0, 0);
        check("t4_count", fifo_count, 4);
        check("t4_ovf", overflow, 1);
        check("t4_head", {word_dir, word_data}, 9'h111);
        clr_ovf = 1;
        tick();
        clr_ovf = 0;
        check("t4_clr_ovf", overflow, 0);

        // 5: full FIFO, push coincides with a pop -> no overflow, order kept
        word(0, 8'h66, 1, 1);
        check("t5_count", fifo_count, 4);
        check("t5_ovf", overflow, 0);
        check("t5_head", {word_dir, word_data}, 9'h022);
        drain();
        check("t5_empty", word_valid, 0);

        // 6: reset mid-word with two words queued discards everything
        word(1, 8'h77, 1, 0);
        word(1, 8'h88, 1, 0);
        for (int i = 0; i < 5; i++) shift(1);
        rst_n = 0;
        exp_q.delete();
        tick();
        rst_n = 1;
        check("t6_count", fifo_count, 0);
        check("t6_valid", word_valid, 0);
        for (int i = 0; i < 7; i++) shift(1);
        check("t6_partial", fifo_count, 0);
        shift(1);
        par_in = 8'h99;
        exp_q.push_back({1'b1, 8'h99});
        tick();
        par_in = 0;
        tick();
        check("t6_one_word", fifo_count, 1);
        check("t6_abort", abort, 0);
        drain();
        check("all_consumed", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
